ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] SHALL be 00.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request valid toward instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_addr  output  32  byte address of requested word, equal to pc.
REQ-007 imem_rsp_valid  input  1  fetched word valid this cycle.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 dec_valid  output  1  instruction held for the ctrl decoder.
REQ-010 dec_ready  input  1  decoder/datapath consumes the held instruction this cycle.
REQ-011 instr  output  32  registered instruction word.
REQ-012 op  output  7  instr[6:0].
REQ-013 funct3  output  3  instr[14:12].
REQ-014 funct7  output  1  instr[30].
REQ-015 pc  output  32  address of the held/requested instruction.
REQ-016 pcSrc  input  1  branch/jump taken for the held instruction; sampled only at consume.
REQ-017 pc_target  input  32  redirect address, used when pcSrc=1.
REQ-018 illegal  output  1  held instr[1:0] != 2'b11.
REQ-019 retired  output  32  count of consumed instructions.

Function
REQ-020 FSM states SHALL be REQ, WAIT, HOLD.
REQ-021 REQ: imem_req_valid=1; on imem_req_ready=1 next state WAIT, else stay REQ.
REQ-022 WAIT: imem_req_valid=0; on imem_rsp_valid=1 latch imem_rsp_data into instr, next state HOLD; else stay WAIT.
REQ-023 HOLD: dec_valid=1; instr/op/funct3/funct7/illegal SHALL stay stable until consume.
REQ-024 Consume = HOLD and dec_ready=1; next state REQ, retired increments by 1.
REQ-025 At consume, pc SHALL load {pc_target[31:2],2'b00} if pcSrc=1, else pc+4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
REQ-026 pcSrc and pc_target SHALL be ignored outside consume.
REQ-027 dec_valid SHALL be 0 in REQ and WAIT; imem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-028 imem_rsp_valid in REQ or HOLD SHALL be dropped with no state change.
REQ-029 imem_addr SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-030 Minimum throughput: one instruction per 3 cycles (REQ, WAIT, HOLD, each one cycle).
REQ-031 retired SHALL wrap FFFF_FFFF -> 0000_0000.
REQ-032 op/funct3/funct7/illegal SHALL derive combinationally from registered instr only.

Reset
REQ-033 When rst=1 at a clock edge: state=REQ, pc=RESET_PC, instr=32'h0000_0013 (nop), retired=0.
REQ-034 During and immediately after reset: dec_valid=0, illegal=0, imem_req_valid=1 from the first non-reset cycle.
REQ-035 Reset SHALL override all inputs in any state, including mid-WAIT and mid-HOLD; a response pending at reset is discarded.

Verification
REQ-036 Reset, ready=1, rsp 32'h0000_0513 one cycle after accept, dec_ready=1 -> imem_addr=0, dec_valid on 3rd cycle, op=7'b0010011, funct3=0, next imem_addr=4, retired=1.
REQ-037 Hold dec_ready=0 for 5 cycles in HOLD with instr 32'h0080_0063 (beq) -> dec_valid and instr stable, pc unchanged, no new request; then dec_ready=1, pcSrc=1, pc_target=32'h0000_0102 -> next imem_addr=32'h0000_0100.
REQ-038 imem_req_ready=0 for 4 cycles -> imem_req_valid=1, imem_addr constant throughout; rsp_valid pulse during those cycles ignored.
REQ-039 pc=32'hFFFF_FFFC, consume with pcSrc=0 -> pc=0; retired preset near FFFF_FFFF via 2^32-1 consumes not required, check wrap by forcing or long-run model.
REQ-040 Assert rst in WAIT, then rsp_valid arrives -> state REQ, pc=RESET_PC, dec_valid=0, response dropped.
REQ-041 rsp word 32'h0000_0000 -> illegal=1 while held; funct7=0; sw word 32'h0020_A023 -> op=7'b0100011, funct3=3'b010, illegal=0.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit.
// Requests one instruction word at a time from instruction memory, holds it for
// the decoder until it is consumed, then advances pc sequentially or to a
// redirect target. Each instruction walks REQ -> WAIT -> HOLD; the request,
// response and consume handshakes each cost at least one cycle.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] pc,
  input  logic        pcSrc,
  input  logic [31:0] pc_target,
  output logic        illegal,
  output logic [31:0] retired
);

  // Canonical nop (addi x0, x0, 0) held after reset so the decode fields are benign.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Word-aligned reset address, so a misconfigured parameter cannot leave pc misaligned.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        consume_s;

  // Address of the next instruction once the held one is consumed.
  // The redirect target is forced word-aligned; the sequential path wraps mod 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] cur_pc,
                                          input logic        taken,
                                          input logic [31:0] target);
    logic [31:0] result;
    if (taken) begin
      result = target & 32'hFFFF_FFFC;
    end else begin
      result = cur_pc + 32'd4;
    end
    return result;
  endfunction

  // A 32-bit base-ISA word always ends in 2'b11; anything else is flagged.
  function automatic logic is_illegal(input logic [31:0] word);
    return (word[1:0] != 2'b11);
  endfunction

  assign consume_s = (state_q == S_HOLD) && dec_ready;

  // Next-state, pc, instruction and retire-count logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_REQ: begin
        // Responses arriving here are stray and are dropped.
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // pcSrc/pc_target only matter in the consume cycle.
        if (consume_s) begin
          pc_d      = next_pc(pc_q, pcSrc, pc_target);
          retired_d = retired_q + 32'd1;
          state_d   = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    imem_req_valid = 1'b0;
    dec_valid      = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req_valid = 1'b1;
      end
      S_WAIT: begin
        imem_req_valid = 1'b0;
      end
      S_HOLD: begin
        dec_valid = 1'b1;
      end
      default: begin
        imem_req_valid = 1'b0;
        dec_valid      = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= NOP_INSTR;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Everything below comes straight from registers, so imem_addr and the
  // decode fields are stable for as long as the owning state persists.
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[30];
  assign illegal   = is_illegal(instr_q);
  assign retired   = retired_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios with literal expectations
// followed by randomized traffic, all compared each cycle against a
// transaction-level model of one instruction's life (requested, accepted, held).
module tb_ifetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] pc;
  logic        pcSrc;
  logic [31:0] pc_target;
  logic        illegal;
  logic [31:0] retired;

  int n_chk;
  int n_pass;

  // Model: an instruction is either being asked for, accepted and awaited, or held.
  bit          m_accepted;
  bit          m_held;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;

  ifetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .instr          (instr),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .pc             (pc),
    .pcSrc          (pcSrc),
    .pc_target      (pc_target),
    .illegal        (illegal),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented at that edge.
  task automatic model_edge();
    if (rst) begin
      m_accepted = 1'b0;
      m_held     = 1'b0;
      m_pc       = RST_PC;
      m_instr    = 32'h0000_0013;
      m_retired  = 32'd0;
    end else if (m_held) begin
      if (dec_ready) begin
        m_held    = 1'b0;
        m_retired = m_retired + 32'd1;
        if (pcSrc) m_pc = {pc_target[31:2], 2'b00};
        else       m_pc = m_pc + 32'd4;
      end
    end else if (m_accepted) begin
      if (imem_rsp_valid) begin
        m_accepted = 1'b0;
        m_held     = 1'b1;
        m_instr    = imem_rsp_data;
      end
    end else begin
      if (imem_req_ready) m_accepted = 1'b1;
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    logic [31:0] w;
    w = m_instr;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, (!m_accepted && !m_held)});
    chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_held});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr", instr, w);
    chk("op", {25'd0, op}, {25'd0, w[6:0]});
    chk("funct3", {29'd0, funct3}, {29'd0, w[14:12]});
    chk("funct7", {31'd0, funct7}, {31'd0, w[30]});
    chk("illegal", {31'd0, illegal}, {31'd0, (w[1:0] != 2'b11)});
    chk("retired", retired, m_retired);
  endtask

  // Drive one cycle of inputs, clock it, and check outputs at the falling edge.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic dr, input logic ps, input logic [31:0] pt);
    rst            = r;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    dec_ready      = dr;
    pcSrc          = ps;
    pc_target      = pt;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_accepted = 1'b0;
    m_held     = 1'b0;
    m_pc       = RST_PC;
    m_instr    = 32'h0000_0013;
    m_retired  = 32'd0;

    // Reset for two cycles with junk on every input.
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1234_5678);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1234_5678);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_retired", retired, 32'd0);

    // Basic fetch: accept, respond one cycle later, consume.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0513, 1'b0, 1'b0, 32'd0);
    chk("hold_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("addi_op", {25'd0, op}, 32'h0000_0013);
    chk("addi_funct3", {29'd0, funct3}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("seq_addr", imem_addr, 32'h0000_0004);
    chk("retired_one", retired, 32'd1);

    // Memory stalls four cycles; a stray response in REQ must be dropped.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, (i == 2), 32'hBAD0_0BAD, 1'b0, 1'b0, 32'd0);
      chk("stall_addr", imem_addr, 32'h0000_0004);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0080_0063, 1'b0, 1'b0, 32'd0);

    // Decoder stalls five cycles; redirect inputs toggling meanwhile are ignored.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0F00);
      chk("beq_instr", instr, 32'h0080_0063);
      chk("beq_pc", pc, 32'h0000_0004);
      chk("beq_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0102);
    chk("redirect_addr", imem_addr, 32'h0000_0100);

    // All-zero word is illegal; redirect to the top word of the address space.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
    chk("zero_illegal", {31'd0, illegal}, 32'd1);
    chk("zero_funct7", {31'd0, funct7}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);

    // Store word at the top address, then sequential wrap to zero.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0020_A023, 1'b0, 1'b0, 32'd0);
    chk("sw_op", {25'd0, op}, 32'h0000_0023);
    chk("sw_funct3", {29'd0, funct3}, 32'd2);
    chk("sw_illegal", {31'd0, illegal}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("retired_four", retired, 32'd4);

    // Reset in WAIT, with the response arriving during reset and just after.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h1111_1117, 1'b1, 1'b0, 32'd0);
    chk("rstw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rstw_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rstw_addr", imem_addr, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b1, 32'h2222_2227, 1'b0, 1'b0, 32'd0);
    chk("rstw_dropped", instr, 32'h0000_0013);
    chk("rstw_retired", retired, 32'd0);

    // Reset in HOLD.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0533, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0400);
    chk("rsth_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rsth_pc", pc, 32'h0000_0000);
    chk("rsth_instr", instr, 32'h0000_0013);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 7) != 0) d[1:0] = 2'b11;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 1) == 1),
           d,
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) < 3),
           $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
